// File: rtl/axis_pack_pkg.sv
// Shared definitions for the AXIS item packer: geometry helpers, keep-mask
// builder and FSM state encoding.
package axis_pack_pkg;

    // Widest tkeep the mask helper can build (tdata up to 2048 bits).
    localparam int unsigned MAX_KEEP_W = 256;

    // FSM states
    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    // Items per beat
    function automatic int unsigned items_f(input int unsigned data_w,
                                            input int unsigned item_w);
        return data_w / item_w;
    endfunction

    // Byte enables per beat
    function automatic int unsigned keep_w_f(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte-enable mask covering lanes 0..cnt-1
    function automatic logic [MAX_KEEP_W-1:0] lane_keep_f(input int unsigned cnt,
                                                          input int unsigned lane_bytes);
        logic [MAX_KEEP_W-1:0] mask;
        mask = '0;
        for (int unsigned b = 0; b < MAX_KEEP_W; b++) begin
            if (b < cnt * lane_bytes) mask[b] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_pack_writer_out_reg.sv
// Output holding register for the packer: one AXIS beat plus its sideband.
// Loads only when the caller has established the slot is free or draining,
// so contents stay frozen while valid && !ready.
module axis_out_reg #(
    parameter int unsigned DataW = 512,
    parameter int unsigned KeepW = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DataW-1:0] data_i,
    input  logic [KeepW-1:0] keep_i,
    input  logic             last_i,
    input  logic             flush_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DataW-1:0] data_o,
    output logic [KeepW-1:0] keep_o,
    output logic             last_o,
    output logic             flush_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic [KeepW-1:0] keep_q, keep_d;
    logic             last_q, last_d;
    logic             flush_q, flush_d;

    // Load a new beat, retire an accepted one, otherwise hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        flush_d = flush_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            keep_d  = keep_i;
            last_d  = last_i;
            flush_d = flush_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            flush_q <= flush_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
    assign flush_o = flush_q;

endmodule

// File: rtl/axis_pack_writer.sv
// Packs FIFO items into full-width AXIS beats. An accumulator collects items
// lane by lane; a full (or flushed) accumulator moves into the output register
// so intake continues while the stream is stalled.
module axis_pack_writer
    import axis_pack_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_SORTER_BIT_WIDTH = 32,
    parameter int unsigned C_DROP_ZERO        = 1,
    parameter int unsigned C_BEATS_PER_PKT    = 0
) (
    input  logic                                m_axis_aclk,
    input  logic                                m_axis_aresetn,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic                                m_axis_tlast,
    input  logic                                read_fifo_out,
    input  logic [C_SORTER_BIT_WIDTH-1:0]       out_fifo_item,
    output logic                                fifo_out_i_deq,
    input  logic                                flush_req,
    output logic                                flush_done,
    output logic [31:0]                         beat_count
);

    localparam int unsigned ITEMS      = items_f(C_AXIS_TDATA_WIDTH, C_SORTER_BIT_WIDTH);
    localparam int unsigned KEEP_W     = keep_w_f(C_AXIS_TDATA_WIDTH);
    localparam int unsigned S          = C_SORTER_BIT_WIDTH;
    localparam int unsigned LANE_BYTES = C_SORTER_BIT_WIDTH / 8;
    localparam int unsigned CNT_W      = $clog2(ITEMS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITEMS);

    logic [C_AXIS_TDATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [0:0]                    state_q, state_d;
    logic [31:0]                   pkt_q, pkt_d;
    logic [31:0]                   beat_q, beat_d;

    logic                  ovalid, olast, oflush;
    logic                  bubble, full, move, deq, full_last, load_last, handshake;
    logic [MAX_KEEP_W-1:0] keep_wide;
    logic [KEEP_W-1:0]     load_keep;

    // Move/dequeue decisions for this cycle
    always_comb begin
        bubble    = (C_DROP_ZERO != 0) && (out_fifo_item == '0);
        full      = (cnt_q == CNT_FULL);
        move      = (full || state_q == S_FLUSH) && (!ovalid || m_axis_tready);
        deq       = (state_q == S_FILL) && read_fifo_out && (bubble || !full || move);
        full_last = (C_BEATS_PER_PKT != 0) && full
                    && (pkt_q == 32'(C_BEATS_PER_PKT - 1));
        load_last = (state_q == S_FLUSH) || full_last;
        keep_wide = lane_keep_f(32'(cnt_q), LANE_BYTES);
        load_keep = keep_wide[KEEP_W-1:0];
        handshake = ovalid && m_axis_tready;
    end

    // Accumulator: clear on move, then place a same-cycle item into the freed lane
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (move) begin
            acc_d = '0;
            cnt_d = '0;
        end
        if (deq && !bubble) begin
            for (int unsigned k = 0; k < ITEMS; k++) begin
                if (CNT_W'(k) == cnt_d) acc_d[k*S +: S] = out_fifo_item;
            end
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // FSM and per-packet full-beat counter
    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        if (state_q == S_FILL) begin
            if (flush_req) state_d = S_FLUSH;
            if (move)      pkt_d   = full_last ? 32'd0 : pkt_q + 32'd1;
        end else if (move) begin
            state_d = S_FILL;
            pkt_d   = 32'd0;
        end
        beat_d = handshake ? beat_q + 32'd1 : beat_q;
    end

    // State registers
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_FILL;
            pkt_q   <= '0;
            beat_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            pkt_q   <= pkt_d;
            beat_q  <= beat_d;
        end
    end

    axis_out_reg #(
        .DataW (C_AXIS_TDATA_WIDTH),
        .KeepW (KEEP_W)
    ) u_out_reg (
        .clk_i   (m_axis_aclk),
        .rst_ni  (m_axis_aresetn),
        .load_i  (move),
        .data_i  (acc_q),
        .keep_i  (load_keep),
        .last_i  (load_last),
        .flush_i (state_q == S_FLUSH),
        .ready_i (m_axis_tready),
        .valid_o (ovalid),
        .data_o  (m_axis_tdata),
        .keep_o  (m_axis_tkeep),
        .last_o  (olast),
        .flush_o (oflush)
    );

    assign m_axis_tvalid  = ovalid;
    assign m_axis_tlast   = olast;
    assign fifo_out_i_deq = deq;
    assign flush_done     = handshake && oflush;
    assign beat_count     = beat_q;

endmodule

// File: tb/tb_axis_pack_writer.sv
// Scoreboard bench for axis_pack_writer (128-bit beats, 32-bit items).
module tb_axis_pack_writer;

    localparam int unsigned W     = 128;
    localparam int unsigned S     = 32;
    localparam int unsigned ITEMS = W / S;
    localparam int unsigned BPP   = 2;

    typedef struct packed {
        logic [W-1:0]   data;
        logic [W/8-1:0] keep;
        logic           last;
        logic           flush;
    } beat_t;

    logic           clk, rst_n;
    logic           tvalid, tready, tlast;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           read_fifo_out, deq, flush_req, flush_done;
    logic [S-1:0]   item;
    logic [31:0]    beat_count;

    axis_pack_writer #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_SORTER_BIT_WIDTH (S),
        .C_DROP_ZERO        (1),
        .C_BEATS_PER_PKT    (BPP)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdata   (tdata),
        .m_axis_tkeep   (tkeep),
        .m_axis_tlast   (tlast),
        .read_fifo_out  (read_fifo_out),
        .out_fifo_item  (item),
        .fifo_out_i_deq (deq),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .beat_count     (beat_count)
    );

    int           checks = 0;
    int           errors = 0;
    logic [S-1:0] src_q[$];
    beat_t        exp_q[$];
    int           rdy_mode = 0;  // 0: always ready, 1: never, 2: random
    int           gap_pct  = 0;
    int           deq_cnt  = 0;
    int           hs_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Source FIFO and downstream ready, driven just after each rising edge
    initial begin
        tready        = 1'b1;
        read_fifo_out = 1'b0;
        item          = '0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = 1'b0;
                default: tready = ($urandom_range(99) < 60);
            endcase
            if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
                read_fifo_out = 1'b1;
                item          = src_q[0];
            end else begin
                read_fifo_out = 1'b0;
                item          = $urandom;
            end
        end
    end

    // Reference model: gather non-zero popped items, cut beats at ITEMS or on flush
    logic [S-1:0] pending[$];
    int           pkt_m = 0;
    bit           flush_open = 0;

    function automatic beat_t mk_beat(input bit last, input bit fl);
        beat_t b;
        b.data  = '0;
        b.keep  = '0;
        b.last  = last;
        b.flush = fl;
        for (int i = 0; i < pending.size(); i++) begin
            b.data[i*S +: S]         = pending[i];
            b.keep[i*S/8 +: S/8]     = '1;
        end
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            pending.delete();
            pkt_m      = 0;
            flush_open = 0;
        end else begin
            if (deq) begin
                chk("deq_without_valid", read_fifo_out, 1);
                if (src_q.size() > 0) begin
                    if (src_q[0] != '0) pending.push_back(src_q[0]);
                    void'(src_q.pop_front());
                end
                deq_cnt++;
            end
            if (flush_req && !flush_open) begin
                exp_q.push_back(mk_beat(1'b1, 1'b1));
                pending.delete();
                pkt_m      = 0;
                flush_open = 1;
            end else if (pending.size() == ITEMS) begin
                pkt_m++;
                if (pkt_m == BPP) begin
                    exp_q.push_back(mk_beat(1'b1, 1'b0));
                    pkt_m = 0;
                end else begin
                    exp_q.push_back(mk_beat(1'b0, 1'b0));
                end
                pending.delete();
            end
            if (flush_done) flush_open = 0;
        end
    end

    // Monitor: compare every accepted beat against the scoreboard
    bit             prev_stall = 0;
    logic [W-1:0]   prev_data;
    logic [W/8-1:0] prev_keep;
    logic           prev_last;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, prev_data);
                chk("stall_keep", tkeep, prev_keep);
                chk("stall_last", tlast, prev_last);
            end
            if (tvalid && tready) begin
                chk("beat_count", beat_count, hs_cnt);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", tdata, '0);
                    chk("unexpected_beat_present", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.data);
                    chk("tkeep", tkeep, e.keep);
                    chk("tlast", tlast, e.last);
                    chk("flush_done", flush_done, e.flush);
                end
                hs_cnt++;
            end else if (flush_done) begin
                chk("flush_done_without_handshake", 0, 1);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_keep  = tkeep;
            prev_last  = tlast;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0 || tvalid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n < budget), 1);
    endtask

    task automatic push(input logic [S-1:0] v);
        src_q.push_back(v);
    endtask

    // Flush from idle, optionally with a same-cycle item and a repeated request
    task automatic do_flush(input bit with_item, input logic [S-1:0] v, input bit twice);
        rdy_mode = 0;
        wait_idle(2000);
        gap_pct = 0;
        if (with_item) push(v);
        @(posedge clk);
        #1 flush_req = 1'b1;
        if (twice) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 flush_req = 1'b0;
        wait_idle(2000);
    endtask

    initial begin
        logic [S-1:0] v;
        rst_n     = 1'b1;
        flush_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tdata", tdata, 0);
        chk("reset_tkeep", tkeep, 0);
        chk("reset_tlast", tlast, 0);
        chk("reset_flush_done", flush_done, 0);
        chk("reset_beat_count", beat_count, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Four items make one full beat
        @(negedge clk);
        deq_cnt = 0;
        for (int i = 1; i <= 4; i++) push(S'(i));
        wait_idle(200);
        chk("deq_cycles_4", deq_cnt, 4);
        chk("beat_count_1", beat_count, 1);

        // Zero items are dropped
        deq_cnt = 0;
        push(5); push(0); push(6); push(0); push(7); push(8);
        wait_idle(200);
        chk("deq_cycles_bubbles", deq_cnt, 6);
        chk("beat_count_2", beat_count, 2);

        // Downstream stall: intake stops with two beats buffered
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        deq_cnt = 0;
        for (int i = 1; i <= 12; i++) push(S'(i));
        repeat (15) @(negedge clk);
        chk("stall_deq_count", deq_cnt, 8);
        chk("stall_tvalid", tvalid, 1);
        chk("stall_head", tdata, 128'h00000004_00000003_00000002_00000001);
        rdy_mode = 0;
        wait_idle(200);

        // Partial flush, then next item lands in lane 0
        push(1); push(2);
        do_flush(0, 0, 0);
        for (int i = 9; i <= 12; i++) push(S'(i));
        wait_idle(200);

        // Null flush, repeated flush request, then packet framing
        do_flush(0, 0, 0);
        do_flush(0, 0, 1);
        for (int i = 1; i <= 16; i++) push(S'(i + 100));
        wait_idle(400);
        push(3); push(4); push(5);
        do_flush(1, 6, 0);

        // Randomized traffic with occasional flushes
        for (int r = 0; r < 60; r++) begin
            rdy_mode = ($urandom_range(1) == 0) ? 0 : 2;
            gap_pct  = $urandom_range(50);
            for (int i = 0; i < int'($urandom_range(12, 1)); i++) begin
                v = ($urandom_range(3) == 0) ? '0 : S'($urandom);
                push(v);
            end
            repeat ($urandom_range(8)) @(negedge clk);
            if ($urandom_range(3) == 0) begin
                v = S'($urandom_range(255));
                do_flush($urandom_range(1) == 1, v, $urandom_range(1) == 1);
            end
        end
        rdy_mode = 0;
        wait_idle(4000);
        chk("final_beat_count", beat_count, hs_cnt);

        // Asynchronous reset while a beat is held
        rdy_mode = 1;
        gap_pct  = 0;
        for (int i = 1; i <= 6; i++) push(S'(i));
        for (int n = 0; n < 50 && !tvalid; n++) @(negedge clk);
        chk("pre_reset_tvalid", tvalid, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        hs_cnt = 0;
        #1;
        chk("async_tvalid", tvalid, 0);
        chk("async_tdata", tdata, 0);
        chk("async_tkeep", tkeep, 0);
        chk("async_tlast", tlast, 0);
        chk("async_beat_count", beat_count, 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        push(21); push(22); push(23); push(24);
        wait_idle(200);
        chk("post_reset_beat_count", beat_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
